// File: rtl/nes_pad_reader.sv
// Host-side NES controller poller: drives latch/clock to a 4021 pad and shifts in
// eight active-low button bits, publishing them active-high on btns.
module nes_pad_reader #(
    parameter int HALF_PERIOD = 6,
    parameter int POLL_PERIOD = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       poll_req,
    input  logic       pad_data,
    output logic       pad_latch,
    output logic       pad_clk,
    output logic [7:0] btns,
    output logic       btns_valid,
    output logic       busy
);

    localparam int DIV_W = ($clog2(2 * HALF_PERIOD) < 3) ? 3 : $clog2(2 * HALF_PERIOD);
    localparam logic [DIV_W-1:0] LATCH_LD = DIV_W'(2 * HALF_PERIOD - 1);
    localparam logic [DIV_W-1:0] HALF_LD  = DIV_W'(HALF_PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [DIV_W-1:0] div_q;
    logic [2:0]       idx_q;
    logic [7:0]       shift_q;
    logic             sync1_q;
    logic             data_s_q;
    logic             latch_q;
    logic             pclk_q;
    logic [7:0]       btns_q;
    logic             valid_q;
    logic             busy_q;
    logic             wrap;

    generate
        if (POLL_PERIOD > 0) begin : g_auto
            localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
            logic [PW-1:0] poll_q;
            assign wrap = (poll_q == PW'(POLL_PERIOD - 1));
            always_ff @(posedge clk) begin
                if (rst || wrap) poll_q <= '0;
                else             poll_q <= poll_q + PW'(1);
            end
        end else begin : g_noauto
            assign wrap = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b1;
            data_s_q <= 1'b1;
            state_q  <= S_IDLE;
            div_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '1;
            latch_q  <= 1'b0;
            pclk_q   <= 1'b0;
            btns_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            sync1_q  <= pad_data;
            data_s_q <= sync1_q;
            valid_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (poll_req || wrap) begin
                        state_q <= S_LATCH;
                        div_q   <= LATCH_LD;
                        latch_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                S_LATCH: begin
                    if (div_q == '0) begin
                        state_q <= S_LOW;
                        div_q   <= HALF_LD;
                        idx_q   <= '0;
                        latch_q <= 1'b0;
                    end else begin
                        div_q <= div_q - 1'b1;
                    end
                end
                S_LOW: begin
                    if (div_q == '0) begin
                        shift_q[idx_q] <= data_s_q;
                        if (idx_q == 3'd7) begin
                            // Last bit is folded in here so btns is already valid during DONE.
                            state_q <= S_DONE;
                            div_q   <= '0;
                            btns_q  <= ~{data_s_q, shift_q[6:0]};
                            valid_q <= 1'b1;
                        end else begin
                            state_q <= S_HIGH;
                            div_q   <= HALF_LD;
                            pclk_q  <= 1'b1;
                        end
                    end else begin
                        div_q <= div_q - 1'b1;
                    end
                end
                S_HIGH: begin
                    if (div_q == '0) begin
                        state_q <= S_LOW;
                        div_q   <= HALF_LD;
                        idx_q   <= idx_q + 3'd1;
                        pclk_q  <= 1'b0;
                    end else begin
                        div_q <= div_q - 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign pad_latch  = latch_q;
    assign pad_clk    = pclk_q;
    assign btns       = btns_q;
    assign btns_valid = valid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_nes_pad_reader.sv
// Scoreboard bench for nes_pad_reader: one instance without auto-poll, one with
// POLL_PERIOD=200, each driven by a 4021-style pad model and a poll-timing model.
`timescale 1ns/1ps
module tb_nes_pad_reader;

    localparam int H   = 4;
    localparam int LAT = 17 * H;  // trigger edge -> edge that raises btns_valid

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst        [2];
    logic       poll_req   [2];
    logic       pad_latch  [2];
    logic       pad_clk    [2];
    logic [7:0] btns       [2];
    logic       btns_valid [2];
    logic       busy       [2];
    logic [7:0] pressed    [2];
    logic       disc       [2];
    int         cyc        [2];
    int         since      [2];
    int         vcount     [2];
    int         total = 0;
    int         bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int P  = (g == 0) ? 0 : 200;
        localparam int PD = (P == 0) ? 1 : P;

        int   exp_btn  [$];
        int   exp_edge [$];
        int   idle_at = 0;
        int   pidx = 0;
        logic ppclk = 1'b0;
        logic pclk_prev = 1'b0;
        logic valid_prev = 1'b0;
        int   latch_n = 0;
        int   rise_n = 0;
        int   busy_n = 0;
        logic pd;

        assign pd = disc[g] ? 1'b1 : ~pressed[g][pidx[2:0]];

        nes_pad_reader #(.HALF_PERIOD(H), .POLL_PERIOD(P)) u_dut (
            .clk        (clk),
            .rst        (rst[g]),
            .poll_req   (poll_req[g]),
            .pad_data   (pd),
            .pad_latch  (pad_latch[g]),
            .pad_clk    (pad_clk[g]),
            .btns       (btns[g]),
            .btns_valid (btns_valid[g]),
            .busy       (busy[g])
        );

        // Pad: latch reloads bit 0 (A), each rising pad_clk advances one bit.
        always @(negedge clk) begin
            if (pad_latch[g])                    pidx = 0;
            else if (pad_clk[g] && !ppclk && pidx < 7) pidx = pidx + 1;
            ppclk = pad_clk[g];
        end

        // Reference: a trigger in an idle window starts a poll lasting 17H+2 edges.
        always @(posedge clk) begin
            bit trig;
            cyc[g] = cyc[g] + 1;
            if (rst[g]) begin
                since[g] = 0;
                idle_at  = 0;
                exp_btn.delete();
                exp_edge.delete();
            end else begin
                trig     = poll_req[g] || (P != 0 && (since[g] % PD) == PD - 1);
                since[g] = since[g] + 1;
                if (trig && cyc[g] >= idle_at) begin
                    exp_btn.push_back(disc[g] ? 0 : int'(pressed[g]));
                    exp_edge.push_back(cyc[g] + LAT);
                    idle_at = cyc[g] + LAT + 2;
                end
            end
        end

        always @(negedge clk) begin
            check($sformatf("overlap%0d", g), int'(pad_latch[g] & pad_clk[g]), 0);
            if (!busy[g]) begin
                latch_n = 0;
                rise_n  = 0;
                busy_n  = 0;
            end
            if (pad_latch[g]) latch_n++;
            if (pad_clk[g] && !pclk_prev) rise_n++;
            if (busy[g]) busy_n++;
            if (btns_valid[g]) begin
                vcount[g]++;
                if (valid_prev) check($sformatf("valid_width%0d", g), 2, 1);
                if (exp_btn.size() == 0) begin
                    check($sformatf("unexpected_valid%0d", g), 1, 0);
                end else begin
                    check($sformatf("btns%0d", g), int'(btns[g]), exp_btn.pop_front());
                    check($sformatf("latency%0d", g), cyc[g], exp_edge.pop_front());
                    check($sformatf("latch_cycles%0d", g), latch_n, 2 * H);
                    check($sformatf("clk_rises%0d", g), rise_n, 7);
                    check($sformatf("busy_cycles%0d", g), busy_n, LAT + 1);
                end
            end else if (exp_edge.size() != 0 && cyc[g] > exp_edge[0]) begin
                check($sformatf("missing_valid%0d", g), cyc[g], exp_edge[0]);
                void'(exp_btn.pop_front());
                void'(exp_edge.pop_front());
            end
            pclk_prev  = pad_clk[g];
            valid_prev = btns_valid[g];
        end
    end

    task automatic check_idle_outputs(input int g, input string tag);
        check({tag, "_btns"},  int'(btns[g]), 0);
        check({tag, "_valid"}, int'(btns_valid[g]), 0);
        check({tag, "_busy"},  int'(busy[g]), 0);
        check({tag, "_latch"}, int'(pad_latch[g]), 0);
        check({tag, "_pclk"},  int'(pad_clk[g]), 0);
    endtask

    task automatic pulse_now(input int g);
        poll_req[g] = 1'b1;
        @(negedge clk);
        poll_req[g] = 1'b0;
    endtask

    task automatic wait_until(input int g, input int target, input int limit);
        int k = 0;
        while (vcount[g] < target && k < limit) begin
            @(negedge clk);
            k++;
        end
        check($sformatf("valid_count%0d", g), vcount[g], target);
    endtask

    task automatic poll_once(input int g, input logic [7:0] p);
        int s;
        pressed[g] = p;
        @(negedge clk);
        s = vcount[g];
        pulse_now(g);
        wait_until(g, s + 1, 200);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_phase(input int g, input int ph);
        int k = 0;
        while ((since[g] % 200) != ph && k < 400) begin
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int g = 0; g < 2; g++) begin
            rst[g]      = 1'b1;
            poll_req[g] = 1'b0;
            disc[g]     = 1'b0;
            pressed[g]  = (g == 0) ? 8'h00 : 8'h01;
        end
        repeat (3) @(negedge clk);
        check_idle_outputs(0, "reset0");
        check_idle_outputs(1, "reset1");
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        fork
            begin : inst0
                int s;
                repeat (5) @(negedge clk);
                poll_once(0, 8'h08);
                poll_once(0, 8'hA5);
                poll_once(0, 8'h00);
                disc[0] = 1'b1;
                poll_once(0, 8'h5A);
                disc[0] = 1'b0;
                for (int i = 0; i < 6; i++) poll_once(0, 8'($urandom));

                // request during LOW of bit 4 must be ignored
                pressed[0] = 8'h77;
                @(negedge clk);
                s = vcount[0];
                pulse_now(0);
                repeat (41) @(negedge clk);
                pulse_now(0);
                wait_until(0, s + 1, 200);
                repeat (100) @(negedge clk);
                check("ignored_req", vcount[0], s + 1);

                // reset during HIGH of bit 2
                poll_once(0, 8'h3C);
                pressed[0] = 8'($urandom);
                @(negedge clk);
                pulse_now(0);
                repeat (29) @(negedge clk);
                check("pre_rst_pclk", int'(pad_clk[0]), 1);
                check("pre_rst_btns", int'(btns[0]), 8'h3C);
                rst[0] = 1'b1;
                @(negedge clk);
                check_idle_outputs(0, "abort");
                rst[0] = 1'b0;
                repeat (3) @(negedge clk);
                poll_once(0, 8'($urandom));
            end
            begin : inst1
                int s;
                s = vcount[1];
                wait_until(1, s + 2, 500);

                // poll_req coinciding with a wrap gives one poll
                wait_phase(1, 199);
                s = vcount[1];
                pulse_now(1);
                wait_until(1, s + 1, 200);
                repeat (30) @(negedge clk);
                check("coincide_single", vcount[1], s + 1);

                // wrap landing inside a request-started poll is dropped
                wait_phase(1, 150);
                s = vcount[1];
                pulse_now(1);
                repeat (150) @(negedge clk);
                check("dropped_wrap", vcount[1], s + 1);
                wait_until(1, s + 2, 300);
            end
        join

        repeat (20) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
